// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side signal bundle for hazard_ctrl
// Perf counter signals exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_if;
  logic        mem_do_read_ctrl_ex;
  logic [4:0]  wr_reg_idx_ex;
  logic [4:0]  r1_reg_idx_id;
  logic [4:0]  r2_reg_idx_id;
  logic        uses_rs1_id;
  logic        uses_rs2_id;
  logic        branch_taken_ex;
  logic        do_jump_ex;
  logic        imem_ready;
  logic        dmem_req_mem;
  logic        dmem_ready;
  logic        pc_enable;
  logic        if_id_enable;
  logic        if_id_clear;
  logic        id_ex_enable;
  logic        id_ex_clear;
  logic        ex_mem_enable;
  logic        ex_mem_clear;
  logic        mem_wb_enable;
  logic        mem_wb_clear;
  logic        bus_error;
  logic [1:0]  hz_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_load_use_cnt;
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_dwait_cnt;
`endif

  modport master (
    output mem_do_read_ctrl_ex, wr_reg_idx_ex, r1_reg_idx_id, r2_reg_idx_id,
           uses_rs1_id, uses_rs2_id, branch_taken_ex, do_jump_ex, imem_ready,
           dmem_req_mem, dmem_ready,
    input  pc_enable, if_id_enable, if_id_clear, id_ex_enable, id_ex_clear,
           ex_mem_enable, ex_mem_clear, mem_wb_enable, mem_wb_clear,
           bus_error, hz_state
`ifdef HAZARD_PERF_CNT_EN
    , input perf_load_use_cnt, perf_flush_cnt, perf_dwait_cnt
`endif
  );

  modport slave (
    input  mem_do_read_ctrl_ex, wr_reg_idx_ex, r1_reg_idx_id, r2_reg_idx_id,
           uses_rs1_id, uses_rs2_id, branch_taken_ex, do_jump_ex, imem_ready,
           dmem_req_mem, dmem_ready,
    output pc_enable, if_id_enable, if_id_clear, id_ex_enable, id_ex_clear,
           ex_mem_enable, ex_mem_clear, mem_wb_enable, mem_wb_clear,
           bus_error, hz_state
`ifdef HAZARD_PERF_CNT_EN
    , output perf_load_use_cnt, perf_flush_cnt, perf_dwait_cnt
`endif
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard/stall controller with dmem watchdog
// Optional performance counters are compiled in with HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int unsigned DMEM_TIMEOUT = 255
) (
  input logic          clk,
  input logic          clear,
  hazard_ctrl_if.slave hz
);
  localparam int unsigned CW = (DMEM_TIMEOUT == 0) ? 1 : $clog2(DMEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(DMEM_TIMEOUT);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DWAIT = 2'd1, ST_ERR = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          bus_error_q;
  logic          load_use, redirect, dstall;
  logic [4:0]    en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
  logic [3:0]    clr;  // {if_id, id_ex, ex_mem, mem_wb}

  assign load_use = hz.mem_do_read_ctrl_ex && (hz.wr_reg_idx_ex != 5'd0) &&
                    ((hz.uses_rs1_id && (hz.r1_reg_idx_id == hz.wr_reg_idx_ex)) ||
                     (hz.uses_rs2_id && (hz.r2_reg_idx_id == hz.wr_reg_idx_ex)));
  assign redirect = hz.branch_taken_ex || hz.do_jump_ex;
  assign dstall   = hz.dmem_req_mem && !hz.dmem_ready;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_error_q <= bus_error_q || (state_d == ST_ERR);
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (dstall) begin
          state_d    = ST_DWAIT;
          wait_cnt_d = CW'(1);
        end
      end
      ST_DWAIT: begin
        // Completion is checked first so a late dmem_ready beats the timeout.
        if (hz.dmem_ready || !hz.dmem_req_mem) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if ((DMEM_TIMEOUT != 0) && (wait_cnt_q == TMAX)) begin
          state_d = ST_ERR;
        end else if ((DMEM_TIMEOUT != 0) && (wait_cnt_q != TMAX)) begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      default: state_d = ST_ERR;
    endcase
  end

  always_comb begin
    en  = 5'b11111;
    clr = 4'b0000;
    if (clear) begin
      en  = 5'b00000;
      clr = 4'b1111;
    end else if (state_q == ST_ERR) begin
      en  = 5'b00000;
    end else if (dstall) begin
      en  = 5'b00000;
      clr = 4'b0001;
    end else if (redirect) begin
      clr = 4'b1100;
    end else if (load_use) begin
      en  = 5'b00111;
      clr = 4'b0100;
    end else if (!hz.imem_ready) begin
      en  = 5'b01111;
      clr = 4'b1000;
    end
  end

  assign hz.pc_enable     = en[4];
  assign hz.if_id_enable  = en[3];
  assign hz.id_ex_enable  = en[2];
  assign hz.ex_mem_enable = en[1];
  assign hz.mem_wb_enable = en[0];
  assign hz.if_id_clear   = clr[3];
  assign hz.id_ex_clear   = clr[2];
  assign hz.ex_mem_clear  = clr[1];
  assign hz.mem_wb_clear  = clr[0];
  assign hz.bus_error     = bus_error_q;
  assign hz.hz_state      = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_q, perf_fl_q, perf_dw_q;
  logic        live;

  assign live = !clear && (state_q != ST_ERR);

  always_ff @(posedge clk) begin
    if (clear) begin
      perf_lu_q <= '0;
      perf_fl_q <= '0;
      perf_dw_q <= '0;
    end else if (live) begin
      if (dstall)        perf_dw_q <= perf_dw_q + 32'd1;
      else if (redirect) perf_fl_q <= perf_fl_q + 32'd1;
      else if (load_use) perf_lu_q <= perf_lu_q + 32'd1;
    end
  end

  assign hz.perf_load_use_cnt = perf_lu_q;
  assign hz.perf_flush_cnt    = perf_fl_q;
  assign hz.perf_dwait_cnt    = perf_dw_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
// Vector table, hand sequences and random stimulus against a rule-level model.
module tb_hazard_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  logic clear;
  hazard_ctrl_if hz();
  hazard_ctrl #(.DMEM_TIMEOUT(N)) dut (.clk(clk), .clear(clear), .hz(hz));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       clr, ld;
    logic [4:0] wr, r1, r2;
    logic       u1, u2, br, jmp, imr, req, rdy;
  } stim_t;

  typedef struct {
    string      name;
    stim_t      s;
    logic [8:0] exp;
  } vec_t;

  // {pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr, ex_mem_en, ex_mem_clr, mem_wb_en, mem_wb_clr}
  localparam logic [8:0] C_RUN = 9'b110101010;
  localparam logic [8:0] C_CLR = 9'b001010101;
  localparam logic [8:0] C_ERR = 9'b000000000;
  localparam logic [8:0] C_DST = 9'b000000001;
  localparam logic [8:0] C_RED = 9'b111111010;
  localparam logic [8:0] C_LU  = 9'b000111010;
  localparam logic [8:0] C_IMS = 9'b011101010;

  int          vecs;
  int          errs;
  int          m_state;
  int          m_streak;
  int          m_berr;
  logic [31:0] m_lu, m_fl, m_dw;
  vec_t        tbl[12];

  function automatic stim_t mk(logic clr, logic ld, logic [4:0] wr, logic [4:0] r1,
                               logic [4:0] r2, logic u1, logic u2, logic br, logic jmp,
                               logic imr, logic req, logic rdy);
    stim_t s;
    s.clr = clr; s.ld = ld; s.wr = wr; s.r1 = r1; s.r2 = r2; s.u1 = u1; s.u2 = u2;
    s.br = br; s.jmp = jmp; s.imr = imr; s.req = req; s.rdy = rdy;
    return s;
  endfunction

  function automatic vec_t mv(string name, stim_t s, logic [8:0] exp);
    vec_t v;
    v.name = name; v.s = s; v.exp = exp;
    return v;
  endfunction

  function automatic logic [8:0] model_ctl(stim_t s, int st);
    bit lu, ds;
    lu = s.ld && (s.wr != 0) && ((s.u1 && s.r1 == s.wr) || (s.u2 && s.r2 == s.wr));
    ds = s.req && !s.rdy;
    if (s.clr)          return C_CLR;
    if (st == 2)        return C_ERR;
    if (ds)             return C_DST;
    if (s.br || s.jmp)  return C_RED;
    if (lu)             return C_LU;
    if (!s.imr)         return C_IMS;
    return C_RUN;
  endfunction

  function automatic logic [8:0] get_ctl();
    return {hz.pc_enable, hz.if_id_enable, hz.if_id_clear, hz.id_ex_enable, hz.id_ex_clear,
            hz.ex_mem_enable, hz.ex_mem_clear, hz.mem_wb_enable, hz.mem_wb_clear};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(stim_t s);
    clear                  = s.clr;
    hz.mem_do_read_ctrl_ex = s.ld;
    hz.wr_reg_idx_ex       = s.wr;
    hz.r1_reg_idx_id       = s.r1;
    hz.r2_reg_idx_id       = s.r2;
    hz.uses_rs1_id         = s.u1;
    hz.uses_rs2_id         = s.u2;
    hz.branch_taken_ex     = s.br;
    hz.do_jump_ex          = s.jmp;
    hz.imem_ready          = s.imr;
    hz.dmem_req_mem        = s.req;
    hz.dmem_ready          = s.rdy;
  endtask

  // Watchdog seen as "more than N consecutive stall cycles", not as a counter FSM.
  task automatic model_update(stim_t s);
    logic [8:0] c;
    c = model_ctl(s, m_state);
    if (s.clr) begin
      m_state = 0; m_streak = 0; m_berr = 0;
      m_lu = 0; m_fl = 0; m_dw = 0;
    end else begin
      if (c == C_DST) m_dw++;
      if (c == C_RED) m_fl++;
      if (c == C_LU)  m_lu++;
      if (m_state != 2) begin
        if (s.req && !s.rdy) begin
          m_streak++;
          m_state = (m_streak > N) ? 2 : 1;
        end else begin
          m_streak = 0;
          m_state  = 0;
        end
      end
      if (m_state == 2) m_berr = 1;
    end
  endtask

  // exp_st / exp_be of -1 mean "take the expectation from the model".
  task automatic cycle(string nm, stim_t s, logic [8:0] exp, bit use_exp, int exp_st, int exp_be);
    drive(s);
    #4;
    chk({nm, ".ctl"}, 32'(get_ctl()), 32'(use_exp ? exp : model_ctl(s, m_state)));
    chk({nm, ".state"}, 32'(hz.hz_state), 32'((exp_st < 0) ? m_state : exp_st));
    chk({nm, ".bus_error"}, 32'(hz.bus_error), 32'((exp_be < 0) ? m_berr : exp_be));
`ifdef HAZARD_PERF_CNT_EN
    chk({nm, ".perf_lu"}, hz.perf_load_use_cnt, m_lu);
    chk({nm, ".perf_fl"}, hz.perf_flush_cnt, m_fl);
    chk({nm, ".perf_dw"}, hz.perf_dwait_cnt, m_dw);
`endif
    @(posedge clk);
    #1;
    model_update(s);
  endtask

  initial begin
    stim_t idle, stall, done, lu, clr, s;
    vecs = 0; errs = 0;
    m_state = 0; m_streak = 0; m_berr = 0; m_lu = 0; m_fl = 0; m_dw = 0;

    idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    stall = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    done  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    lu    = mk(0, 1, 5, 3, 5, 0, 1, 0, 0, 1, 0, 0);
    clr   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    drive(clr);
    @(posedge clk);
    #1;
    model_update(clr);
    cycle("reset", clr, C_CLR, 1, 0, 0);
    cycle("post_reset", idle, C_RUN, 1, 0, 0);

    tbl[0]  = mv("idle",          idle,                                        C_RUN);
    tbl[1]  = mv("lu_rs2",        lu,                                          C_LU);
    tbl[2]  = mv("lu_rs1_unused", mk(0, 1, 5, 5, 0, 0, 0, 0, 0, 1, 0, 0),      C_RUN);
    tbl[3]  = mv("lu_x0",         mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0),      C_RUN);
    tbl[4]  = mv("no_load",       mk(0, 0, 5, 5, 5, 1, 1, 0, 0, 1, 0, 0),      C_RUN);
    tbl[5]  = mv("br_over_lu",    mk(0, 1, 7, 7, 0, 1, 0, 1, 0, 1, 0, 0),      C_RED);
    tbl[6]  = mv("jmp_over_ims",  mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0),      C_RED);
    tbl[7]  = mv("imem_stall",    mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),      C_IMS);
    tbl[8]  = mv("lu_over_ims",   mk(0, 1, 9, 9, 2, 1, 1, 0, 0, 0, 0, 0),      C_LU);
    tbl[9]  = mv("dstall_over_br",mk(0, 1, 9, 9, 0, 1, 0, 1, 0, 1, 1, 0),      C_DST);
    tbl[10] = mv("dmem_done",     done,                                        C_RUN);
    tbl[11] = mv("clear_all",     mk(1, 1, 3, 3, 3, 1, 1, 1, 1, 0, 1, 0),      C_CLR);
    for (int i = 0; i < 12; i++) cycle(tbl[i].name, tbl[i].s, tbl[i].exp, 1, -1, -1);

    cycle("lu_once", lu, C_LU, 1, 0, 0);
    cycle("lu_released", idle, C_RUN, 1, 0, 0);

    cycle("ds1", stall, C_DST, 1, 0, 0);
    cycle("ds2", stall, C_DST, 1, 1, 0);
    cycle("ds3", stall, C_DST, 1, 1, 0);
    cycle("ds_done", done, C_RUN, 1, 1, 0);
    cycle("ds_after", idle, C_RUN, 1, 0, 0);

    s = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
    cycle("br_held1", s, C_DST, 1, 0, 0);
    cycle("br_held2", s, C_DST, 1, 1, 0);
    s.rdy = 1'b1;
    cycle("br_release", s, C_RED, 1, 1, 0);
    cycle("br_after", idle, C_RUN, 1, 0, 0);

    for (int i = 0; i < N; i++) cycle("race_stall", stall, C_DST, 1, (i == 0) ? 0 : 1, 0);
    cycle("race_done", done, C_RUN, 1, 1, 0);
    cycle("race_after", idle, C_RUN, 1, 0, 0);

    for (int i = 0; i <= N; i++) cycle("wd_stall", stall, C_DST, 1, (i == 0) ? 0 : 1, 0);
    cycle("wd_err", done, C_ERR, 1, 2, 1);
    cycle("wd_frozen", lu, C_ERR, 1, 2, 1);
    cycle("wd_clear", clr, C_CLR, 1, 2, 1);
    cycle("wd_recover", idle, C_RUN, 1, 0, 0);

`ifdef HAZARD_PERF_CNT_EN
    cycle("perf_clr", clr, C_CLR, 1, 0, 0);
    cycle("perf_lu1", lu, C_LU, 1, 0, 0);
    cycle("perf_idle", idle, C_RUN, 1, 0, 0);
    cycle("perf_lu2", lu, C_LU, 1, 0, 0);
    cycle("perf_jmp", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), C_RED, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle("perf_ds", stall, C_DST, 1, (i == 0) ? 0 : 1, 0);
    cycle("perf_done", done, C_RUN, 1, 1, 0);
    #4;
    chk("perf_total_lu", hz.perf_load_use_cnt, 32'd2);
    chk("perf_total_fl", hz.perf_flush_cnt, 32'd1);
    chk("perf_total_dw", hz.perf_dwait_cnt, 32'd3);
    @(posedge clk);
    #1;
    model_update(idle);
`endif

    for (int i = 0; i < 3000; i++) begin
      s.clr = ($urandom_range(0, 63) == 0);
      s.ld  = $urandom_range(0, 1) == 1;
      s.wr  = 5'($urandom_range(0, 3));
      s.r1  = 5'($urandom_range(0, 3));
      s.r2  = 5'($urandom_range(0, 3));
      s.u1  = $urandom_range(0, 1) == 1;
      s.u2  = $urandom_range(0, 1) == 1;
      s.br  = ($urandom_range(0, 7) == 0);
      s.jmp = ($urandom_range(0, 15) == 0);
      s.imr = ($urandom_range(0, 3) != 0);
      s.req = $urandom_range(0, 1) == 1;
      s.rdy = ($urandom_range(0, 2) == 0);
      cycle("rand", s, C_RUN, 0, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
